mem_access_sequencer: RTL
=========================

MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 Parameter: TIMEOUT, default 15, MOC wait limit in cycles (1..255).
REQ-002 Parameter: AW, default 32, address width.
REQ-003 CLK  in  1  single clock; all state changes on rising edge.
REQ-004 CLR  in  1  reset, synchronous, active-high.
REQ-005 if_req  in  1  instruction-fetch request, level, held until if_done.
REQ-006 if_addr  in  AW  fetch address; fetch is always a word read (typeData 2'b10).
REQ-007 if_done  out  1  one-cycle pulse: fetch complete, if_rdata valid same cycle.
REQ-008 if_rdata  out  32  fetched word, held until next fetch completes.
REQ-009 d_req  in  1  data request, level, held until d_done.
REQ-010 d_rw  in  1  1 = read, 0 = write.
REQ-011 d_type  in  2  access size, passed to typeData unchanged.
REQ-012 d_addr  in  AW; d_wdata  in  32  data-port address and store data.
REQ-013 d_done  out  1  one-cycle pulse: data access complete; d_rdata  out  32  load data, held.
REQ-014 d_err  out  1  asserted with d_done/if_done pulse when access timed out.
REQ-015 MOV  out  1; RW  out  1; typeData  out  2; mem_addr  out  AW; mem_wdata  out  32  RAM-side strobe, direction, size, address, write data.
REQ-016 MOC  in  1; mem_rdata  in  32  RAM completion and read data.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, ARB, ACCESS, RELEASE, DONE.
REQ-019 IDLE: if if_req or d_req -> ARB next cycle; else stay.
REQ-020 ARB: select requester, latch its addr/rw/type/wdata into internal registers; -> ACCESS.
REQ-021 Only one requester pending: it wins. Both pending: winner is the one NOT granted last (round-robin); after reset, data port wins first tie.
REQ-022 ACCESS: MOV=1, RW/typeData/mem_addr/mem_wdata driven from latched registers, stable for whole access; wait counter increments each cycle.
REQ-023 ACCESS with MOC=1: capture mem_rdata (reads only) into winner's rdata register; -> RELEASE.
REQ-024 ACCESS with counter == TIMEOUT and MOC=0: set error flag; -> RELEASE without updating rdata.
REQ-025 RELEASE: MOV=0; stay until MOC=0 (timeout path: MOC already 0, leaves after 1 cycle); -> DONE.
REQ-026 DONE: pulse winner's done for exactly one cycle, with d_err = error flag; update last-granted; clear counter and error; -> IDLE.
REQ-027 Requester must drop req in the cycle after its done; a req still high in IDLE is a new request.
REQ-028 Latency, MOC responding k cycles after MOV rise and dropping 1 cycle after MOV falls: done pulse k+4 cycles after req sampled in IDLE.
REQ-029 MOV never asserted outside ACCESS; changes on requester inputs during ACCESS/RELEASE have no effect on RAM-side outputs.
REQ-030 Writes: d_rdata unchanged. Fetch never writes (RW=1).
REQ-031 Counter is 8 bits, saturating; no wrap.

Reset
REQ-032 CLR=1 at a rising edge: state IDLE, MOV=0, RW=1, typeData=2'b10, mem_addr=0, mem_wdata=0, if_done=d_done=d_err=0, if_rdata=d_rdata=0, busy=0, counter=0, last-granted=fetch (data wins first tie).
REQ-033 CLR mid-access aborts immediately: MOV=0 next edge, no done pulse issued for the aborted access.

Verification
REQ-034 Fetch only, if_addr=0x10, MOC rises 2 cycles after MOV, mem_rdata=0xE3A0_1005 -> if_done pulse at cycle 6, if_rdata=0xE3A0_1005, RW=1, typeData=2'b10 throughout.
REQ-035 Data write d_rw=0, d_type=2'b00, d_addr=0x20, d_wdata=0xAB -> RW=0, typeData=2'b00, mem_addr=0x20, mem_wdata=0xAB while MOV=1; d_done pulse; d_rdata stays 0.
REQ-036 if_req and d_req rise together after reset -> data served first, fetch second; repeat tie -> fetch served first.
REQ-037 MOC held 0, TIMEOUT=15 -> MOV high exactly 15 cycles, then d_done with d_err=1, d_rdata unchanged.
REQ-038 CLR asserted while in ACCESS -> next edge MOV=0, busy=0, no done pulse; subsequent request completes normally.
REQ-039 MOC stays high 3 cycles after MOV drops -> FSM holds RELEASE, done pulses one cycle after MOC falls.

Source files
------------

// File: rtl/mem_access_sequencer_if.sv
// RAM-side bus of the memory access sequencer: strobe, direction, size, address, data, completion.
interface mem_access_sequencer_if #(
  parameter int unsigned AW = 32
);
  logic          MOV;
  logic          RW;
  logic [1:0]    typeData;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          MOC;
  logic [31:0]   mem_rdata;

  modport master (
    output MOV, RW, typeData, mem_addr, mem_wdata,
    input  MOC, mem_rdata
  );

  modport slave (
    input  MOV, RW, typeData, mem_addr, mem_wdata,
    output MOC, mem_rdata
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Arbitrates a fetch port and a data port onto one RAM strobe/complete bus, round-robin on ties.
// Done pulses k+4 cycles after a request is sampled in IDLE; requesters hold req level while busy.
module mem_access_sequencer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned AW      = 32
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [31:0]   if_rdata,
  input  logic          d_req,
  input  logic          d_rw,
  input  logic [1:0]    d_type,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_done,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          busy,
  mem_access_sequencer_if.master mem
);

  typedef enum logic [2:0] {IDLE, ARB, ACCESS, RELEASE, DONE} state_t;

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          rw_q;
  logic [1:0]    type_q;
  logic          grant_d;
  logic          last_d;
  logic          err_q;
  logic [7:0]    cnt_q;
  logic [7:0]    cnt_inc;
  logic          timeout_hit;
  logic          pick_d;

  // The counter includes the current ACCESS cycle, so MOV stays high exactly TIMEOUT cycles.
  assign cnt_inc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign timeout_hit = (cnt_inc == TO_LIM);

  always_comb begin
    pick_d = d_req;
    if (d_req && if_req)
      pick_d = !last_d;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (if_req || d_req) state_nxt = ARB;
      ARB:     state_nxt = (if_req || d_req) ? ACCESS : IDLE;
      ACCESS:  if (mem.MOC || timeout_hit) state_nxt = RELEASE;
      RELEASE: if (!mem.MOC) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      rw_q     <= 1'b1;
      type_q   <= 2'b10;
      grant_d  <= 1'b0;
      last_d   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ARB: begin
          if (if_req || d_req) begin
            grant_d <= pick_d;
            if (pick_d) begin
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
              rw_q    <= d_rw;
              type_q  <= d_type;
            end else begin
              addr_q  <= if_addr;
              wdata_q <= '0;
              rw_q    <= 1'b1;
              type_q  <= 2'b10;
            end
          end
        end
        ACCESS: begin
          cnt_q <= cnt_inc;
          if (mem.MOC) begin
            if (rw_q) begin
              if (grant_d)
                d_rdata <= mem.mem_rdata;
              else
                if_rdata <= mem.mem_rdata;
            end
          end else if (timeout_hit) begin
            err_q <= 1'b1;
          end
        end
        DONE: begin
          last_d <= grant_d;
          cnt_q  <= '0;
          err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // RAM-side controls come only from the latched copy, never from live requester inputs.
  assign mem.MOV       = (state == ACCESS);
  assign mem.RW        = rw_q;
  assign mem.typeData  = type_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign if_done = (state == DONE) && !grant_d;
  assign d_done  = (state == DONE) && grant_d;
  assign d_err   = (state == DONE) && err_q;
  assign busy    = (state != IDLE);

endmodule
